// File: rtl/iotdf_pkg.sv
// Shared definitions for the IOT data-filter scheduler: filter function codes,
// FSM state encoding and record geometry.
package iotdf_pkg;

  localparam int IOT_BYTES = 16;

  typedef logic [3:0] fn_t;

  localparam fn_t F_MAX     = 4'd1;
  localparam fn_t F_MIN     = 4'd2;
  localparam fn_t F_AVG     = 4'd3;
  localparam fn_t F_EXTRACT = 4'd4;
  localparam fn_t F_EXCLUDE = 4'd5;
  localparam fn_t F_SUM     = 4'd6;
  localparam fn_t F_MEDIAN  = 4'd7;
  localparam fn_t F_PEAKMAX = 4'd8;
  localparam fn_t F_PEAKMIN = 4'd9;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_SEND  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;

  function automatic logic fn_is_valid(input fn_t fn);
    return (fn >= F_MAX) && (fn <= F_PEAKMIN);
  endfunction

endpackage

// File: rtl/iotdf_sched_if.sv
// Bundle of requester, filter and result signals around the scheduler.
// The scheduler takes the slave view; the environment drives the master view.
interface iotdf_sched_if;
  logic         req0_valid;
  logic         req1_valid;
  logic [3:0]   req0_fn;
  logic [3:0]   req1_fn;
  logic [127:0] req0_data;
  logic [127:0] req1_data;
  logic         req0_ready;
  logic         req1_ready;
  logic         dut_busy;
  logic         dut_valid;
  logic [127:0] dut_out;
  logic         dut_in_en;
  logic [7:0]   dut_iot_in;
  logic [3:0]   dut_fn_sel;
  logic         res_valid;
  logic         res_src;
  logic [127:0] res_data;
  logic         bad_fn;

  modport slave (
    input  req0_valid, req1_valid, req0_fn, req1_fn, req0_data, req1_data,
    input  dut_busy, dut_valid, dut_out,
    output req0_ready, req1_ready, dut_in_en, dut_iot_in, dut_fn_sel,
    output res_valid, res_src, res_data, bad_fn
  );

  modport master (
    output req0_valid, req1_valid, req0_fn, req1_fn, req0_data, req1_data,
    output dut_busy, dut_valid, dut_out,
    input  req0_ready, req1_ready, dut_in_en, dut_iot_in, dut_fn_sel,
    input  res_valid, res_src, res_data, bad_fn
  );
endinterface

// File: rtl/iotdf_rr_arb.sv
// Two-way round-robin arbiter: on a tie the requester not granted last wins;
// the priority pointer only moves when the scheduler finishes a batch.
module iotdf_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic       grant
);

  logic prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (advance) prio_d = ~owner;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  assign grant = (req[0] && req[1]) ? prio_q : req[1];

endmodule

// File: rtl/iotdf_sched.sv
// Batch scheduler in front of an IOT data filter: grants one requester per
// batch, streams its records byte by byte and tags the filter results.
module iotdf_sched
  import iotdf_pkg::*;
#(
  parameter int RECS_PER_BATCH = 8,
  parameter int DRAIN_CYC      = 4
) (
  input logic          clk,
  input logic          rst_n,
  iotdf_sched_if.slave bus
);

  localparam int RW = $clog2(RECS_PER_BATCH + 1);
  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [RW-1:0] LAST_REC   = RW'(RECS_PER_BATCH - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(DRAIN_CYC - 1);
  localparam logic [3:0]    LAST_BYTE  = 4'(IOT_BYTES - 1);

  logic [2:0]    state_q, state_d;
  logic          owner_q, owner_d;
  fn_t           fn_sel_q, fn_sel_d;
  logic [127:0]  rec_q, rec_d;
  logic [3:0]    byte_idx_q, byte_idx_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          bad_fn_q, bad_fn_d;
  logic          res_valid_q, res_valid_d;
  logic          res_src_q, res_src_d;
  logic [127:0]  res_data_q, res_data_d;

  logic [1:0]    arb_req;
  logic          arb_grant;
  logic          arb_advance;
  fn_t           grant_fn;
  logic          own_valid;
  logic [127:0]  own_data;

  assign arb_req   = {bus.req1_valid, bus.req0_valid};
  assign grant_fn  = arb_grant ? bus.req1_fn : bus.req0_fn;
  assign own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
  assign own_data  = owner_q ? bus.req1_data : bus.req0_data;

  iotdf_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (arb_advance),
    .owner   (owner_q),
    .grant   (arb_grant)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    fn_sel_d    = fn_sel_q;
    rec_d       = rec_q;
    byte_idx_d  = byte_idx_q;
    rec_cnt_d   = rec_cnt_q;
    drain_cnt_d = drain_cnt_q;
    bad_fn_d    = 1'b0;
    arb_advance = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|arb_req) begin
          owner_d     = arb_grant;
          fn_sel_d    = grant_fn;
          rec_cnt_d   = '0;
          byte_idx_d  = '0;
          drain_cnt_d = '0;
          if (fn_is_valid(grant_fn)) begin
            state_d = S_LOAD;
          end else begin
            bad_fn_d = 1'b1;
            state_d  = S_FLUSH;
          end
        end
      end
      S_LOAD: begin
        if (own_valid) begin
          rec_d      = own_data;
          byte_idx_d = '0;
          state_d    = S_SEND;
        end
      end
      S_SEND: begin
        if (!bus.dut_busy) begin
          byte_idx_d = byte_idx_q + 4'd1;
          if (byte_idx_q == LAST_BYTE) begin
            rec_cnt_d = rec_cnt_q + RW'(1);
            if (rec_cnt_q == LAST_REC) begin
              drain_cnt_d = '0;
              state_d     = S_DRAIN;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
      end
      // The filter may still be chewing on the tail; a busy cycle restarts the wait.
      S_DRAIN: begin
        if (bus.dut_busy) begin
          drain_cnt_d = '0;
        end else if (drain_cnt_q == LAST_DRAIN) begin
          arb_advance = 1'b1;
          state_d     = S_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q + DW'(1);
        end
      end
      S_FLUSH: begin
        if (own_valid) begin
          if (rec_cnt_q == LAST_REC) begin
            arb_advance = 1'b1;
            state_d     = S_IDLE;
          end else begin
            rec_cnt_d = rec_cnt_q + RW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_valid_d = bus.dut_valid;
    res_src_d   = bus.dut_valid ? owner_q : res_src_q;
    res_data_d  = bus.dut_valid ? bus.dut_out : res_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      fn_sel_q    <= '0;
      rec_q       <= '0;
      byte_idx_q  <= '0;
      rec_cnt_q   <= '0;
      drain_cnt_q <= '0;
      bad_fn_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_src_q   <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fn_sel_q    <= fn_sel_d;
      rec_q       <= rec_d;
      byte_idx_q  <= byte_idx_d;
      rec_cnt_q   <= rec_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      bad_fn_q    <= bad_fn_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      res_data_q  <= res_data_d;
    end
  end

  assign bus.req0_ready = ((state_q == S_LOAD) || (state_q == S_FLUSH)) && !owner_q;
  assign bus.req1_ready = ((state_q == S_LOAD) || (state_q == S_FLUSH)) && owner_q;
  assign bus.dut_in_en  = (state_q == S_SEND) && !bus.dut_busy;
  assign bus.dut_iot_in = (state_q == S_SEND) ? rec_q[{byte_idx_q, 3'b000} +: 8] : 8'd0;
  assign bus.dut_fn_sel = fn_sel_q;
  assign bus.bad_fn     = bad_fn_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_src    = res_src_q;
  assign bus.res_data   = res_data_q;

endmodule

// File: tb/tb_iotdf_sched.sv
// Scoreboard bench for iotdf_sched: random records per batch, a batch-level
// round-robin model builds the expected byte/accept/result streams.
`timescale 1ns/1ps
module tb_iotdf_sched;

  localparam int RECS = 8;
  localparam int DCYC = 4;

  typedef struct { logic [3:0] fn; logic [127:0] data; int gap; } rec_t;
  typedef struct { logic src; logic [127:0] data; } acc_t;
  typedef struct { logic [7:0] b; logic [3:0] fn; logic src; int bidx; int ridx; logic [127:0] rec; } byte_t;
  typedef struct { logic src; logic [127:0] data; int cyc; } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iotdf_sched_if bus();

  iotdf_sched #(.RECS_PER_BATCH(RECS), .DRAIN_CYC(DCYC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rec_t  drv_q0[$], drv_q1[$];
  rec_t  pend0[$], pend1[$];
  acc_t  exp_acc[$];
  byte_t exp_bytes[$];
  res_t  exp_res[$];

  int total = 0;
  int bad = 0;
  int exp_bad = 0;
  int bad_seen = 0;
  bit mprio = 1'b0;
  bit started0 = 1'b0, started1 = 1'b0;
  int gap0 = 0, gap1 = 0;
  bit res_pend = 1'b0;
  logic res_pend_src;
  logic [127:0] res_pend_rec;
  int res_pend_ridx;
  bit have_last = 1'b0;
  int last_end = 0;
  bit stall7 = 1'b0, stall_done = 1'b0, busy_rand = 1'b0;
  int stall_left = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Queue one batch of RECS records for a requester; gaps only inside the batch.
  task automatic applyStimulus(input int src, input logic [3:0] fn, input bit gaps);
    rec_t r;
    for (int k = 0; k < RECS; k++) begin
      r.fn   = fn;
      r.data = {$urandom(), $urandom(), $urandom(), $urandom()};
      r.gap  = (gaps && k != 0) ? int'($urandom_range(0, 3)) : 0;
      if (src == 0) begin drv_q0.push_back(r); pend0.push_back(r); end
      else          begin drv_q1.push_back(r); pend1.push_back(r); end
    end
  endtask

  // Batch-level reference: pick owners round-robin, expand records into expectations.
  task automatic runModel();
    rec_t r;
    logic src;
    logic [3:0] bfn;
    while (pend0.size() > 0 || pend1.size() > 0) begin
      if (pend0.size() > 0 && pend1.size() > 0) src = mprio;
      else src = (pend1.size() > 0);
      mprio = !src;
      bfn = src ? pend1[0].fn : pend0[0].fn;
      if (bfn == 0 || bfn > 9) exp_bad++;
      for (int k = 0; k < RECS; k++) begin
        r = src ? pend1.pop_front() : pend0.pop_front();
        exp_acc.push_back('{src, r.data});
        if (bfn >= 1 && bfn <= 9)
          for (int j = 0; j < 16; j++)
            exp_bytes.push_back('{r.data[8*j +: 8], bfn, src, j, k, r.data});
      end
    end
  endtask

  task automatic checkReset(input string name);
    checkOutput({name, "_req0_ready"}, bus.req0_ready, 0);
    checkOutput({name, "_req1_ready"}, bus.req1_ready, 0);
    checkOutput({name, "_in_en"},      bus.dut_in_en, 0);
    checkOutput({name, "_iot_in"},     bus.dut_iot_in, 0);
    checkOutput({name, "_fn_sel"},     bus.dut_fn_sel, 0);
    checkOutput({name, "_res_valid"},  bus.res_valid, 0);
    checkOutput({name, "_res_src"},    bus.res_src, 0);
    checkOutput({name, "_res_data"},   bus.res_data, 0);
    checkOutput({name, "_bad_fn"},     bus.bad_fn, 0);
  endtask

  task automatic clearModel();
    drv_q0.delete(); drv_q1.delete(); pend0.delete(); pend1.delete();
    exp_acc.delete(); exp_bytes.delete(); exp_res.delete();
    started0 = 0; started1 = 0; res_pend = 0; have_last = 0;
    stall_left = 0; stall_done = 0;
  endtask

  task automatic doReset(input string name);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checkReset(name);
    clearModel();
    mprio = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput({name, "_ready_before_first_edge"}, bus.req0_ready | bus.req1_ready, 0);
  endtask

  task automatic waitDone(input string name);
    int n;
    n = 0;
    while ((exp_bytes.size() > 0 || exp_acc.size() > 0 || drv_q0.size() > 0 || drv_q1.size() > 0
            || res_pend || exp_res.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      total++; bad++;
      $display("[TB] FAIL %s_timeout: got bytes=%0d accepts=%0d pending, required 0", name,
               exp_bytes.size(), exp_acc.size());
      clearModel();
    end
    repeat (DCYC + 6) @(negedge clk);
    checkOutput({name, "_bad_fn_count"}, bad_seen, exp_bad);
  endtask

  // Requester drivers: present queue heads, pop on handshake seen before the edge.
  initial begin : drv
    bit h0, h1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_fn = 0; bus.req1_fn = 0;
    bus.req0_data = 0; bus.req1_data = 0;
    forever begin
      @(negedge clk);
      h0 = bus.req0_valid && bus.req0_ready;
      h1 = bus.req1_valid && bus.req1_ready;
      @(posedge clk); #1;
      if (h0 && drv_q0.size() > 0) begin void'(drv_q0.pop_front()); started0 = 0; end
      if (h1 && drv_q1.size() > 0) begin void'(drv_q1.pop_front()); started1 = 0; end
      if (drv_q0.size() > 0) begin
        if (!started0) begin started0 = 1; gap0 = drv_q0[0].gap; end
        if (gap0 > 0) begin
          gap0--; bus.req0_valid = 0;
          bus.req0_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else begin
          bus.req0_valid = 1; bus.req0_fn = drv_q0[0].fn; bus.req0_data = drv_q0[0].data;
        end
      end else begin
        bus.req0_valid = 0; started0 = 0;
      end
      if (drv_q1.size() > 0) begin
        if (!started1) begin started1 = 1; gap1 = drv_q1[0].gap; end
        if (gap1 > 0) begin
          gap1--; bus.req1_valid = 0;
          bus.req1_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        end else begin
          bus.req1_valid = 1; bus.req1_fn = drv_q1[0].fn; bus.req1_data = drv_q1[0].data;
        end
      end else begin
        bus.req1_valid = 0; started1 = 0;
      end
    end
  end

  // Filter stall generator: directed 3-cycle stall on byte 7, or random stalls.
  initial begin : busy_drv
    bus.dut_busy = 0;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        bus.dut_busy = 1; stall_left--;
      end else if (stall7 && exp_bytes.size() > 0 && exp_bytes[0].bidx == 7 && !stall_done) begin
        bus.dut_busy = 1; stall_left = 2; stall_done = 1;
      end else begin
        if (exp_bytes.size() == 0 || exp_bytes[0].bidx != 7) stall_done = 0;
        bus.dut_busy = busy_rand && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // Filter model: one result per completed record, the batch's last one is all-0x55.
  initial begin : filt
    bus.dut_valid = 0; bus.dut_out = 0;
    forever begin
      @(posedge clk); #1;
      if (res_pend && rst_n) begin
        res_pend = 0;
        bus.dut_valid = 1;
        bus.dut_out = (res_pend_ridx == RECS - 1) ? {8{16'h5555}} : ~res_pend_rec;
        exp_res.push_back('{res_pend_src, bus.dut_out, cyc + 1});
      end else begin
        bus.dut_valid = 0;
      end
    end
  end

  initial begin : monitor
    byte_t e;
    acc_t a;
    res_t r;
    bit prev_bad;
    prev_bad = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.req0_ready || bus.req1_ready) begin
          checkOutput("ready_exclusive", bus.req0_ready & bus.req1_ready, 0);
          if (exp_acc.size() > 0) checkOutput("ready_owner", bus.req1_ready, exp_acc[0].src);
        end
        if ((bus.req0_valid && bus.req0_ready) || (bus.req1_valid && bus.req1_ready)) begin
          if (exp_acc.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL accept_unexpected: got a handshake, required none");
          end else begin
            a = exp_acc.pop_front();
            checkOutput("accept_src", bus.req1_ready, a.src);
            checkOutput("accept_data", bus.req1_ready ? bus.req1_data : bus.req0_data, a.data);
          end
        end
        if (bus.dut_busy) begin
          checkOutput("in_en_while_busy", bus.dut_in_en, 0);
          if (exp_bytes.size() > 0 && exp_bytes[0].bidx != 0)
            checkOutput("held_byte", bus.dut_iot_in, exp_bytes[0].b);
        end
        if (bus.dut_in_en) begin
          if (exp_bytes.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL byte_unexpected: got byte %h, required no byte", bus.dut_iot_in);
          end else begin
            e = exp_bytes.pop_front();
            checkOutput("byte_value", bus.dut_iot_in, e.b);
            checkOutput("fn_sel", bus.dut_fn_sel, e.fn);
            if (e.bidx == 0 && e.ridx == 0 && have_last) begin
              total++;
              if (cyc - last_end - 1 < DCYC) begin
                bad++;
                $display("[TB] FAIL drain_gap: got %0d idle cycles, required >= %0d", cyc - last_end - 1, DCYC);
              end
            end
            if (e.bidx == 15) begin
              res_pend = 1; res_pend_src = e.src; res_pend_rec = e.rec; res_pend_ridx = e.ridx;
              if (e.ridx == RECS - 1) begin have_last = 1; last_end = cyc; end
            end
          end
        end
        if (bus.bad_fn) begin
          bad_seen++;
          if (prev_bad) begin
            total++; bad++;
            $display("[TB] FAIL bad_fn_width: got 2+ cycles high, required 1");
          end
        end
        prev_bad = bus.bad_fn;
        if (bus.res_valid) begin
          if (exp_res.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL res_unexpected: got %h, required no result", bus.res_data);
          end else begin
            r = exp_res.pop_front();
            checkOutput("res_src", bus.res_src, r.src);
            checkOutput("res_data", bus.res_data, r.data);
            checkOutput("res_latency", cyc, r.cyc);
          end
        end
      end else begin
        prev_bad = 0;
      end
    end
  end

  initial begin : stim
    int n;
    #12;
    checkReset("power_on");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single requester, fn=1");
    applyStimulus(0, 4'd1, 0);
    runModel();
    waitDone("single");

    $display("[TB] tie from reset, fn 3 vs 5");
    doReset("reset_a");
    applyStimulus(0, 4'd3, 0);
    applyStimulus(1, 4'd5, 0);
    runModel();
    waitDone("tie");

    $display("[TB] stall on byte 7");
    stall7 = 1;
    applyStimulus(0, 4'($urandom_range(1, 9)), 1);
    applyStimulus(1, 4'($urandom_range(1, 9)), 1);
    runModel();
    waitDone("stall7");
    stall7 = 0;

    $display("[TB] rejected fn 0xA on req1");
    applyStimulus(1, 4'hA, 0);
    runModel();
    waitDone("bad_fn");

    $display("[TB] random batches with stalls and gaps");
    busy_rand = 1;
    for (int i = 0; i < 6; i++)
      applyStimulus(i % 2,
                    ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(1, 9)), 1);
    runModel();
    waitDone("random");
    busy_rand = 0;

    $display("[TB] reset at byte 9 of record 4");
    applyStimulus(0, 4'd2, 0);
    runModel();
    n = 0;
    while (!(exp_bytes.size() > 0 && exp_bytes[0].ridx == 3 && exp_bytes[0].bidx == 9) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      total++; bad++;
      $display("[TB] FAIL reset_point_timeout: got no byte 9 of record 4, required it");
    end
    doReset("mid_batch");
    repeat (5) @(negedge clk);
    checkOutput("after_reset_idle_in_en", bus.dut_in_en, 0);
    applyStimulus(0, 4'd4, 0);
    applyStimulus(1, 4'd6, 0);
    runModel();
    waitDone("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
